intsrc_adapter: RTL and testbench
=================================

Name: intsrc_adapter

Overview:
- Upstream source stage for the interrupt controller.
- Converts INTCOUNT raw device interrupt lines into the controller's per-source request/ready handshake (intrqstsrc/intrdysrc).
- Each line has an edge/level mode, a pending latch, a mask, and a per-line handshake FSM.
- Software configures and inspects the block through a standard pi1 register port.

Parameters:
- INTCOUNT, 8, number of device lines and source slots; 1 <= INTCOUNT <= ARCHBITSZ.
- ARCHBITSZ, 32, data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).

Ports:
- rst_i  in  1  reset; synchronous, active-high.
- clk_i  in  1  single clock; all logic on rising edge.
- pi1_op_i  in  2  00 NOOP, 01 WR, 10 RD, 11 RW (atomic read-then-write).
- pi1_addr_i  in  ADDRBITSZ  word address; only bits [1:0] decoded.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  registered read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables; ignored, full-word access.
- pi1_rdy_o  out  1  constant 1.
- pi1_mapsz_o  out  ADDRBITSZ  constant 4 (words).
- irq_i  in  INTCOUNT  raw device interrupt lines, active-high.
- intrqstsrc_o  out  INTCOUNT  request to the controller, one per line.
- intrdysrc_i  in  INTCOUNT  controller ready; low means the line is being serviced.

Behaviour:
- Registers (addr[1:0]):
  - 0 MASK: RW, 1 = enabled.
  - 1 MODE: RW, 1 = rising-edge, 0 = level-high.
  - 2 PEND: read = pending bits; write-1-to-clear, edge-mode lines only.
  - 3 STAT: RO, bit i = 1 when line i FSM is not IDLE.
  - Bits >= INTCOUNT read 0 and ignore writes.
- Access timing:
  - RD/RW update pi1_data_o at the clock edge of the op; value is readable the following cycle.
  - RW returns the pre-write value.
  - WR/NOOP leave pi1_data_o unchanged.
- Reset: MASK, MODE, PEND, sample flops and pi1_data_o all 0; every FSM in IDLE; intrqstsrc_o = 0 from the first edge with rst_i high. Reset mid-handshake abandons the handshake; no further request until a new pending event.
- Sampling:
  - irq_s = irq_i registered; irq_p = previous irq_s.
  - Edge mode sets pending when irq_s & !irq_p.
  - Level mode: pending <= irq_s every cycle.
- Per-line FSM:
  - IDLE (intrqst=0): if pending & mask, go to RQST.
  - RQST (intrqst=1): when intrdysrc_i low, go to ACKW; clear pending in edge mode.
  - ACKW (intrqst=0): when intrdysrc_i high, go to IDLE.
  - Mask only gates IDLE->RQST. Clearing the mask in RQST/ACKW does not abort the handshake.
- Latency (no sync): irq_i high before edge k -> pending at edge k+1 -> intrqstsrc_o high after edge k+2.
- Simultaneous events on one line, same cycle:
  - Edge set beats W1C clear and beats handshake clear; a new edge during RQST is kept pending and re-requested after ACKW->IDLE.
  - W1C in RQST does not drop intrqst.
- MODE write clears pending for every line whose mode bit changes, and sets irq_p = irq_s for those lines so that no spurious edge is detected.
- Lines are independent; there is no arbitration. The controller round-robins across lines.

Optional Feature:
- Macro: INTSRC_ADAPTER_SYNC_EN.
- Defined: two-flop synchronizer before irq_s (irq_i -> sync1 -> irq_s). All irq-to-request latencies grow by 1 cycle; reset clears sync1.
- Undefined: irq_i is assumed synchronous to clk_i and is registered once.

Test Plan:
- After reset, MASK=0x01, MODE=0x01; pulse irq_i[0] one cycle -> PEND=0x01; intrqstsrc_o[0] rises 2 edges after the sample edge; hold intrdysrc_i[0] low 3 cycles then high -> intrqstsrc_o[0] low in ACKW, PEND=0, STAT=0 after release.
- Level mode line 1, MASK=0x02, irq_i[1] held high -> repeated request/ack cycles; drop irq_i[1] -> no new request after the current handshake.
- Edge on line 0 in the same cycle as handshake ack (intrdysrc_i[0] low) -> PEND bit stays 1; second request issued after ACKW->IDLE.
- MASK=0, edge on line 2 -> PEND=0x04, intrqstsrc_o=0; write MASK=0x04 -> request rises next cycle+1; write PEND=0x04 while in IDLE with mask 0 -> PEND=0.
- RW to MASK with data 0xFF while MASK=0x05 -> pi1_data_o=0x05; subsequent RD gives 0xFF masked to INTCOUNT bits; pi1_rdy_o=1, pi1_mapsz_o=4 throughout.
- Assert rst_i while line 3 is in RQST -> intrqstsrc_o[3]=0 next edge, all registers 0; with INTSRC_ADAPTER_SYNC_EN defined, repeat the first scenario and expect the request 1 cycle later.

Source files
------------

// File: rtl/intsrc_adapter.sv
// intsrc_adapter: per-line edge/level capture, pending latch, mask and request/ready handshake behind a pi1 register port.
// Define INTSRC_ADAPTER_SYNC_EN to add a two-flop synchronizer in front of the irq sample flops.
module intsrc_adapter #(
  parameter int INTCOUNT  = 8,
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   rst_i,
  input  logic                   clk_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
  input  logic [INTCOUNT-1:0]    irq_i,
  output logic [INTCOUNT-1:0]    intrqstsrc_o,
  input  logic [INTCOUNT-1:0]    intrdysrc_i
);
  localparam logic [1:0] IDLE = 2'd0, RQST = 2'd1, ACKW = 2'd2;
  logic [1:0] r_st [INTCOUNT];
  logic [1:0] w_st_nxt [INTCOUNT];
  logic [INTCOUNT-1:0] r_mask, r_mode, r_pend, r_irq_s, r_irq_p;
  logic [INTCOUNT-1:0] w_in, w_wd, w_edge, w_hs, w_w1c, w_chg, w_pend_nxt, w_stat, w_rd;
  logic [ARCHBITSZ-1:0] r_data;
  logic [1:0] w_addr;
  logic w_wr, w_rd_en, w_unused;
`ifdef INTSRC_ADAPTER_SYNC_EN
  logic [INTCOUNT-1:0] r_sync1;
  always_ff @(posedge clk_i) r_sync1 <= rst_i ? '0 : irq_i;
  assign w_in = r_sync1;
`else
  assign w_in = irq_i;
`endif
  assign w_unused     = ^{pi1_sel_i, pi1_addr_i, pi1_data_i};
  assign pi1_rdy_o    = 1'b1;
  assign pi1_mapsz_o  = ADDRBITSZ'(4);
  assign pi1_data_o   = r_data;
  assign w_addr       = pi1_addr_i[1:0];
  assign w_wr         = pi1_op_i[0];
  assign w_rd_en      = pi1_op_i[1];
  assign w_wd         = pi1_data_i[INTCOUNT-1:0];
  assign w_edge       = r_irq_s & ~r_irq_p;
  assign w_w1c        = (w_wr && w_addr == 2'd2) ? w_wd & r_mode : '0;
  assign w_chg        = (w_wr && w_addr == 2'd1) ? w_wd ^ r_mode : '0;
  // a new edge outranks both clears; a mode change discards whatever was pending
  assign w_pend_nxt   = ~w_chg & ((r_mode & (w_edge | (r_pend & ~w_w1c & ~w_hs))) | (~r_mode & r_irq_s));
  assign w_rd         = w_addr == 2'd0 ? r_mask : w_addr == 2'd1 ? r_mode : w_addr == 2'd2 ? r_pend : w_stat;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_irq_s <= '0;
      r_irq_p <= '0;
      r_data  <= '0;
    end else begin
      r_irq_s <= w_in;
      r_irq_p <= (w_chg & w_in) | (~w_chg & r_irq_s);
      r_pend  <= w_pend_nxt;
      if (w_wr && w_addr == 2'd0) r_mask <= w_wd;
      if (w_wr && w_addr == 2'd1) r_mode <= w_wd;
      if (w_rd_en) r_data <= ARCHBITSZ'(w_rd);
    end
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < INTCOUNT; i++) r_st[i] <= rst_i ? IDLE : w_st_nxt[i];
  always_comb
    for (int i = 0; i < INTCOUNT; i++)
      w_st_nxt[i] = r_st[i] == IDLE ? ((r_pend[i] & r_mask[i]) ? RQST : IDLE) :
                    r_st[i] == RQST ? (intrdysrc_i[i] ? RQST : ACKW) :
                    (intrdysrc_i[i] ? IDLE : ACKW);
  always_comb begin
    intrqstsrc_o = '0;
    w_hs         = '0;
    w_stat       = '0;
    for (int i = 0; i < INTCOUNT; i++) begin
      intrqstsrc_o[i] = r_st[i] == RQST;
      w_hs[i]         = r_st[i] == RQST && !intrdysrc_i[i];
      w_stat[i]       = r_st[i] != IDLE;
    end
  end
endmodule

// File: tb/tb_intsrc_adapter.sv
// tb_intsrc_adapter: directed scenarios with literal checks plus a per-cycle behavioural model of every line.
module tb_intsrc_adapter;
  localparam int N = 8, AW = 30;
`ifdef INTSRC_ADAPTER_SYNC_EN
  localparam int SY = 1;
`else
  localparam int SY = 0;
`endif
  logic clk_i = 0, rst_i = 1;
  logic [1:0] pi1_op_i = 0;
  logic [AW-1:0] pi1_addr_i = '0;
  logic [31:0] pi1_data_i = 0;
  logic [3:0] pi1_sel_i = 4'hF;
  logic [N-1:0] irq_i = '0, intrdysrc_i = '1;
  logic [31:0] pi1_data_o;
  logic pi1_rdy_o;
  logic [AW-1:0] pi1_mapsz_o;
  logic [N-1:0] intrqstsrc_o;
  int n_chk = 0, n_fail = 0;
  bit live = 0;

  intsrc_adapter dut (
    .rst_i(rst_i), .clk_i(clk_i), .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i),
    .pi1_data_i(pi1_data_i), .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i),
    .pi1_rdy_o(pi1_rdy_o), .pi1_mapsz_o(pi1_mapsz_o), .irq_i(irq_i),
    .intrqstsrc_o(intrqstsrc_o), .intrdysrc_i(intrdysrc_i)
  );

  always #5 clk_i = ~clk_i;

  // model: busy line = requesting or awaiting ready release; sample chain feeds pending
  logic [N-1:0] m_mask, m_mode, m_pend, m_s, m_p, m_y, m_req, m_wt, m_in;
  logic [31:0] m_data;
  wire m_wr = pi1_op_i == 2'd1 || pi1_op_i == 2'd3;
  wire m_rd = pi1_op_i == 2'd2 || pi1_op_i == 2'd3;
  wire [1:0] m_a = pi1_addr_i[1:0];
  wire [N-1:0] m_wd = pi1_data_i[N-1:0];
  assign m_in = SY ? m_y : irq_i;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_mask <= '0; m_mode <= '0; m_pend <= '0; m_s <= '0; m_p <= '0;
      m_y <= '0; m_req <= '0; m_wt <= '0; m_data <= '0;
    end else begin
      if (m_rd)
        m_data <= 32'(m_a == 0 ? m_mask : m_a == 1 ? m_mode : m_a == 2 ? m_pend : (m_req | m_wt));
      for (int i = 0; i < N; i++) begin
        if (m_req[i]) begin
          if (!intrdysrc_i[i]) begin m_req[i] <= 0; m_wt[i] <= 1; end
        end else if (m_wt[i]) begin
          if (intrdysrc_i[i]) m_wt[i] <= 0;
        end else if (m_pend[i] && m_mask[i]) m_req[i] <= 1;
        if (m_wr && m_a == 1 && m_wd[i] != m_mode[i]) begin
          m_pend[i] <= 0;
          m_p[i] <= m_in[i];
        end else begin
          m_p[i] <= m_s[i];
          if (!m_mode[i]) m_pend[i] <= m_s[i];
          else if (m_s[i] && !m_p[i]) m_pend[i] <= 1;
          else if ((m_wr && m_a == 2 && m_wd[i]) || (m_req[i] && !intrdysrc_i[i])) m_pend[i] <= 0;
        end
      end
      m_s <= m_in;
      m_y <= irq_i;
      if (m_wr && m_a == 0) m_mask <= m_wd;
      if (m_wr && m_a == 1) m_mode <= m_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i)
    if (live) begin
      chk("model_req", 32'(intrqstsrc_o), 32'(m_req));
      chk("model_rdata", pi1_data_o, m_data);
      chk("rdy", 32'(pi1_rdy_o), 1);
      chk("mapsz", 32'(pi1_mapsz_o), 4);
    end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic do_op(input logic [1:0] op, input int a, input logic [31:0] d);
    pi1_op_i = op; pi1_addr_i = AW'(a); pi1_data_i = d;
    tick(1);
    pi1_op_i = 0;
  endtask

  task automatic pulse(input int i);
    irq_i[i] = 1; tick(1); irq_i[i] = 0;
  endtask

  task automatic wait_rq(input int i);
    for (int k = 0; k < 20 && !intrqstsrc_o[i]; k++) tick(1);
    n_chk++;
    if (!intrqstsrc_o[i]) begin
      n_fail++;
      $display("FAIL wait_rq%0d: got 0 expected 1 within 20 cycles", i);
    end
  endtask

  initial begin
    tick(1);
    live = 1;
    tick(1);
    chk("rst_rq", 32'(intrqstsrc_o), 0);
    chk("rst_data", pi1_data_o, 0);
    rst_i = 0;
    // edge line 0 with a 3-cycle ack
    do_op(1, 0, 32'h01);
    do_op(1, 1, 32'h01);
    pulse(0);
    tick(1 + SY);
    chk("s1_rq_before", 32'(intrqstsrc_o[0]), 0);
    do_op(2, 2, 0);
    chk("s1_pend", pi1_data_o, 32'h01);
    chk("s1_model_pend", 32'(m_data), 32'h01);
    chk("s1_rq_up", 32'(intrqstsrc_o[0]), 1);
    intrdysrc_i[0] = 0;
    tick(1);
    chk("s1_rq_ackw", 32'(intrqstsrc_o[0]), 0);
    do_op(2, 3, 0);
    chk("s1_stat_busy", pi1_data_o, 32'h01);
    tick(1);
    intrdysrc_i[0] = 1;
    tick(1);
    do_op(2, 3, 0);
    chk("s1_stat_idle", pi1_data_o, 0);
    do_op(2, 2, 0);
    chk("s1_pend_clr", pi1_data_o, 0);
    // level line 1
    do_op(1, 0, 32'h02);
    irq_i[1] = 1;
    for (int r = 0; r < 2; r++) begin
      wait_rq(1);
      intrdysrc_i[1] = 0; tick(1); intrdysrc_i[1] = 1; tick(1);
    end
    wait_rq(1);
    irq_i[1] = 0; intrdysrc_i[1] = 0;
    tick(4);
    intrdysrc_i[1] = 1;
    tick(6);
    chk("s2_no_rerq", 32'(intrqstsrc_o[1]), 0);
    do_op(2, 3, 0);
    chk("s2_stat", pi1_data_o, 0);
    // edge arriving on the ack cycle stays pending
    do_op(1, 0, 32'h03);
    pulse(0);
    wait_rq(0);
    pulse(0);
    if (SY) tick(1);
    intrdysrc_i[0] = 0;
    tick(1);
    intrdysrc_i[0] = 1;
    do_op(2, 2, 0);
    chk("s3_pend_kept", pi1_data_o, 32'h01);
    wait_rq(0);
    intrdysrc_i[0] = 0; tick(1); intrdysrc_i[0] = 1; tick(2);
    do_op(2, 2, 0);
    chk("s3_pend_done", pi1_data_o, 0);
    // masked pending, unmask, then W1C
    do_op(1, 0, 0);
    do_op(1, 1, 32'h05);
    pulse(2);
    tick(2 + SY);
    do_op(2, 2, 0);
    chk("s4_pend", pi1_data_o, 32'h04);
    chk("s4_rq_masked", 32'(intrqstsrc_o), 0);
    do_op(1, 0, 32'h04);
    chk("s4_rq_next", 32'(intrqstsrc_o[2]), 0);
    tick(1);
    chk("s4_rq_up", 32'(intrqstsrc_o[2]), 1);
    intrdysrc_i[2] = 0; tick(1); intrdysrc_i[2] = 1; tick(2);
    do_op(1, 0, 0);
    pulse(2);
    tick(2 + SY);
    do_op(2, 2, 0);
    chk("s4_pend2", pi1_data_o, 32'h04);
    do_op(1, 2, 32'h04);
    do_op(2, 2, 0);
    chk("s4_w1c", pi1_data_o, 0);
    // RW returns pre-write value
    do_op(1, 0, 32'h05);
    do_op(3, 0, 32'hFF);
    chk("s5_rw_old", pi1_data_o, 32'h05);
    do_op(2, 0, 0);
    chk("s5_rd_new", pi1_data_o, 32'hFF & ((32'h1 << N) - 1));
    // reset while line 3 is requesting
    irq_i[3] = 1;
    wait_rq(3);
    rst_i = 1;
    tick(1);
    chk("s6_rq_rst", 32'(intrqstsrc_o), 0);
    chk("s6_data_rst", pi1_data_o, 0);
    rst_i = 0; irq_i[3] = 0;
    for (int a = 0; a < 4; a++) begin
      do_op(2, a, 0);
      chk($sformatf("s6_reg%0d", a), pi1_data_o, 0);
    end
    tick(3);
    chk("s6_quiet", 32'(intrqstsrc_o), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
